// File: rtl/la_iorxdiff_filter.sv
// Receiver-side conditioning for a pseudo-differential pair: synchronize both legs,
// filter glitches with a programmable persistence count, and flag a stuck non-complementary pair.
module la_iorxdiff_filter #(
   parameter     PROP   = "DEFAULT",
   parameter int SYNCW  = 2,
   parameter int FILTW  = 4,
   parameter int FAULTN = 3
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             en,
   input  logic             zp,
   input  logic             zn,
   input  logic [FILTW-1:0] thresh,
   input  logic             fault_clr,
   output logic             z,
   output logic             rise,
   output logic             fall,
   output logic             fault
);

   localparam int         IW        = $clog2(FAULTN + 1);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] STABLE    = 2'd1;
   localparam logic [1:0] QUAL      = 2'd2;
   localparam logic [IW:0] FAULT_LIM = (IW + 1)'(FAULTN);

   logic [SYNCW-1:0] sp_chain_r;
   logic [SYNCW-1:0] sn_chain_r;
   logic             sp_s;
   logic             sn_s;
   logic             valid_s;

   logic [1:0]       state_r;
   logic [1:0]       state_n;
   logic [FILTW-1:0] cnt_r;
   logic [FILTW-1:0] cnt_n;
   logic [FILTW-1:0] t_eff_s;
   logic [FILTW:0]   cnt_inc_s;
   logic             z_r;
   logic             z_n;
   logic             rise_r;
   logic             rise_n;
   logic             fall_r;
   logic             fall_n;
   logic             flip_s;

   logic [IW-1:0]    icnt_r;
   logic [IW-1:0]    icnt_n;
   logic [IW:0]      icnt_inc_s;
   logic             set_s;
   logic             fault_r;
   logic             fault_n;

   // Per-leg synchronizers; the idle pattern (0,1) matches the receiver with its input disabled.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sp_chain_r <= '0;
         sn_chain_r <= '1;
      end else begin
         sp_chain_r <= {sp_chain_r[SYNCW-2:0], zp};
         sn_chain_r <= {sn_chain_r[SYNCW-2:0], zn};
      end
   end

   assign sp_s       = sp_chain_r[SYNCW-1];
   assign sn_s       = sn_chain_r[SYNCW-1];
   assign valid_s    = sp_s ^ sn_s;
   assign t_eff_s    = (thresh == {FILTW{1'b0}}) ? FILTW'(1) : thresh;
   assign cnt_inc_s  = {1'b0, cnt_r} + (FILTW + 1)'(1);
   assign icnt_inc_s = {1'b0, icnt_r} + (IW + 1)'(1);

   // Glitch-filter FSM: a new level must persist for T_eff valid samples before z follows.
   always_comb begin
      state_n = state_r;
      z_n     = z_r;
      cnt_n   = cnt_r;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      flip_s  = 1'b0;
      if (!en) begin
         state_n = IDLE;
         z_n     = 1'b0;
         cnt_n   = '0;
      end else begin
         case (state_r)
            IDLE: state_n = STABLE;
            STABLE: begin
               if (valid_s && (sp_s != z_r)) begin
                  if (t_eff_s == FILTW'(1)) begin
                     flip_s = 1'b1;
                  end else begin
                     cnt_n   = FILTW'(1);
                     state_n = QUAL;
                  end
               end else begin
                  state_n = STABLE;
               end
            end
            QUAL: begin
               // An invalid sample neither advances nor rejects a qualification in progress.
               if (valid_s) begin
                  if (sp_s == z_r) begin
                     cnt_n   = '0;
                     state_n = STABLE;
                  end else if (cnt_inc_s >= {1'b0, t_eff_s}) begin
                     flip_s = 1'b1;
                  end else begin
                     cnt_n = cnt_inc_s[FILTW-1:0];
                  end
               end else begin
                  state_n = QUAL;
               end
            end
            default: begin
               state_n = IDLE;
               z_n     = 1'b0;
               cnt_n   = '0;
            end
         endcase
         if (flip_s) begin
            z_n     = sp_s;
            cnt_n   = '0;
            state_n = STABLE;
            rise_n  = sp_s;
            fall_n  = ~sp_s;
         end else begin
            rise_n  = 1'b0;
            fall_n  = 1'b0;
         end
      end
   end

   // Fault tracking runs regardless of en; a set in the same cycle overrides a clear.
   always_comb begin
      set_s   = 1'b0;
      icnt_n  = icnt_r;
      fault_n = fault_r;
      if (!valid_s) begin
         set_s  = (icnt_inc_s >= FAULT_LIM);
         icnt_n = set_s ? FAULT_LIM[IW-1:0] : icnt_inc_s[IW-1:0];
      end else begin
         set_s  = 1'b0;
         icnt_n = '0;
      end
      if (set_s) begin
         fault_n = 1'b1;
      end else if (fault_clr) begin
         fault_n = 1'b0;
         icnt_n  = '0;
      end else begin
         fault_n = fault_r;
      end
   end

   // State, output and counter registers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         z_r     <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
         icnt_r  <= '0;
         fault_r <= 1'b0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         z_r     <= z_n;
         rise_r  <= rise_n;
         fall_r  <= fall_n;
         icnt_r  <= icnt_n;
         fault_r <= fault_n;
      end
   end

   assign z     = z_r;
   assign rise  = rise_r;
   assign fall  = fall_r;
   assign fault = fault_r;

endmodule

// File: tb/tb_la_iorxdiff_filter.sv
// Self-checking bench for la_iorxdiff_filter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_la_iorxdiff_filter;

   localparam int SYNCW  = 2;
   localparam int FILTW  = 4;
   localparam int FAULTN = 3;

   logic             clk = 1'b0;
   logic             nreset;
   logic             en;
   logic             zp;
   logic             zn;
   logic [FILTW-1:0] thresh;
   logic             fault_clr;
   logic             z;
   logic             rise;
   logic             fall;
   logic             fault;

   int n_chk  = 0;
   int n_fail = 0;
   int k;
   bit seen;
   bit seen2;

   // Model: delay lines for the legs, the filtered level and a single run counter.
   bit qp[$];
   bit qn[$];
   bit mz, mrise, mfall, mfault, marmed;
   int mcnt, micnt;

   la_iorxdiff_filter #(.PROP("DEFAULT"), .SYNCW(SYNCW), .FILTW(FILTW), .FAULTN(FAULTN)) dut (
      .clk(clk), .nreset(nreset), .en(en), .zp(zp), .zn(zn), .thresh(thresh),
      .fault_clr(fault_clr), .z(z), .rise(rise), .fall(fall), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      qp.delete();
      qn.delete();
      for (int i = 0; i < SYNCW; i++) begin
         qp.push_back(1'b0);
         qn.push_back(1'b1);
      end
      mz = 0; mrise = 0; mfall = 0; mfault = 0; marmed = 0; mcnt = 0; micnt = 0;
   endtask

   task automatic model_step();
      bit sp, sn, valid, set;
      int t;
      if (!nreset) begin
         model_reset();
         return;
      end
      sp = qp.pop_front();
      sn = qn.pop_front();
      qp.push_back(zp);
      qn.push_back(zn);
      valid = sp ^ sn;
      t = (thresh == 0) ? 1 : int'(thresh);
      mrise = 0;
      mfall = 0;
      if (!en) begin
         mz = 0; mcnt = 0; marmed = 0;
      end else if (!marmed) begin
         marmed = 1;
      end else if (valid) begin
         if (sp != mz) begin
            if (mcnt + 1 >= t) begin
               mrise = sp; mfall = !sp; mz = sp; mcnt = 0;
            end else begin
               mcnt = mcnt + 1;
            end
         end else begin
            mcnt = 0;
         end
      end
      set = !valid && (micnt + 1 >= FAULTN);
      micnt = valid ? 0 : ((micnt + 1 > FAULTN) ? FAULTN : micnt + 1);
      if (set) mfault = 1;
      else if (fault_clr) begin
         mfault = 0; micnt = 0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wait_z(input logic want, input int maxc, output int kk);
      kk = -1;
      for (int i = 1; i <= maxc; i++) begin
         cyc();
         if (z === want) begin
            kk = i;
            return;
         end
      end
   endtask

   task automatic async_reset();
      #2 nreset = 1'b0;
      model_reset();
      #1;
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (nreset === 1'b1) begin
         check("z_vs_model", z, mz);
         check("rise_vs_model", rise, mrise);
         check("fall_vs_model", fall, mfall);
         check("fault_vs_model", fault, mfault);
      end
   end

   initial begin
      nreset = 1'b1; en = 1'b0; zp = 1'b0; zn = 1'b1; thresh = 4'd3; fault_clr = 1'b0;
      model_reset();
      #1 nreset = 1'b0;
      #1;
      check("reset_z", z, 0);
      check("reset_rise", rise, 0);
      check("reset_fall", fall, 0);
      check("reset_fault", fault, 0);
      repeat (2) @(posedge clk);
      #2 nreset = 1'b1;

      // Clean rise, thresh=3: z follows 5 edges after capture.
      en = 1'b1;
      repeat (4) cyc();
      zp = 1'b1; zn = 1'b0;
      wait_z(1'b1, 12, k);
      check("t1_latency", k, 5);
      check("t1_rise", rise, 1);
      check("t1_fall", fall, 0);
      check("t1_fault", fault, 0);
      cyc();
      check("t1_rise_once", rise, 0);

      // Glitch rejection with thresh=4.
      thresh = 4'd4;
      zp = 1'b0; zn = 1'b1;
      wait_z(1'b0, 20, k);
      check("t2_settle_latency", k, 6);
      repeat (3) cyc();
      zp = 1'b1; zn = 1'b0;
      cyc(); cyc();
      zp = 1'b0; zn = 1'b1;
      seen = 0; seen2 = 0;
      repeat (10) begin
         cyc();
         if (rise) seen = 1;
         if (z) seen2 = 1;
      end
      check("t2_no_rise", seen, 0);
      check("t2_z_low", seen2, 0);
      zp = 1'b1; zn = 1'b0;
      wait_z(1'b1, 20, k);
      check("t2_full_requal_latency", k, 6);

      // thresh=0 behaves as 1.
      thresh = 4'd0;
      repeat (3) cyc();
      zp = 1'b0; zn = 1'b1;
      wait_z(1'b0, 12, k);
      check("t3_latency", k, 3);
      check("t3_fall", fall, 1);
      check("t3_rise", rise, 0);
      cyc();
      check("t3_fall_once", fall, 0);

      // Fault detection, stickiness and clear priority.
      repeat (3) cyc();
      zp = 1'b1; zn = 1'b1;
      cyc(); cyc();
      zp = 1'b0; zn = 1'b1;
      repeat (6) cyc();
      check("t4_two_invalid", fault, 0);
      zp = 1'b1; zn = 1'b1;
      repeat (3) cyc();
      zp = 1'b0; zn = 1'b1;
      repeat (6) cyc();
      check("t4_three_invalid_sticky", fault, 1);
      fault_clr = 1'b1;
      cyc();
      fault_clr = 1'b0;
      check("t4_clear", fault, 0);
      zp = 1'b1; zn = 1'b1;
      repeat (6) cyc();
      check("t4_persistent_set", fault, 1);
      fault_clr = 1'b1;
      repeat (4) begin
         cyc();
         check("t4_set_beats_clr", fault, 1);
      end
      zp = 1'b0; zn = 1'b1;
      repeat (4) cyc();
      fault_clr = 1'b0;
      check("t4_clear_after_recover", fault, 0);

      // Enable drop, re-enable latency and asynchronous reset in QUAL.
      thresh = 4'd3;
      zp = 1'b1; zn = 1'b0;
      wait_z(1'b1, 12, k);
      en = 1'b0;
      cyc();
      check("t5_en_off_z", z, 0);
      check("t5_en_off_fall", fall, 0);
      zp = 1'b0; zn = 1'b1;
      repeat (3) cyc();
      en = 1'b1; zp = 1'b1; zn = 1'b0;
      wait_z(1'b1, 12, k);
      check("t5_reenable_latency", k, 5);
      check("t5_reenable_rise", rise, 1);
      thresh = 4'd8;
      zp = 1'b0; zn = 1'b1;
      repeat (5) cyc();
      async_reset();
      check("t5_async_z", z, 0);
      check("t5_async_rise", rise, 0);
      check("t5_async_fall", fall, 0);
      check("t5_async_fault", fault, 0);
      cyc();
      #2 nreset = 1'b1;

      // Invalid sample during QUAL holds the count.
      thresh = 4'd4;
      repeat (4) cyc();
      zp = 1'b1; zn = 1'b0;
      cyc(); cyc();
      zp = 1'b0; zn = 1'b0;
      cyc();
      zp = 1'b1; zn = 1'b0;
      wait_z(1'b1, 12, k);
      check("t6_latency", (k < 0) ? k : 3 + k, 7);
      check("t6_rise", rise, 1);

      // Randomized traffic; the negedge compare process checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if ($urandom_range(0, 9) == 0) zp = ~zp;
         case ($urandom_range(0, 19))
            0:       zn = zp;
            1:       zn = zn;
            default: zn = ~zp;
         endcase
         if ($urandom_range(0, 99) == 0) thresh = 4'($urandom_range(0, 6));
         if ($urandom_range(0, 199) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
         fault_clr = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 999) == 0) begin
            async_reset();
            check("rand_async_z", z, 0);
            cyc();
            #2 nreset = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
